bk_kbd_decoder: RTL and testbench
=================================

// Module: bk_kbd_decoder
// PURPOSE
//  Upstream neighbour of bkcore. Consumes deserialized PS/2 set-2 scancode bytes and runs
//  the prefix FSM and modifier tracking. Translates keys into BK-0010 key codes and queues
//  them in a small FIFO. Drives bkcore's kbd_available/kbd_data/kbd_ar2/stopkey/superkey/
//  keydown inputs and pops on bkcore's read_kbd strobe.
// PARAMETERS
//  FIFO_DEPTH  4  key FIFO entries, power of 2, >=2
//  GAP_CE      2  ce ticks kbd_available stays low after a pop, so bkcore sees a fresh rising edge
// PORTS
//  clk            in   1  core clock
//  reset          in   1  asynchronous, active-high
//  ce             in   1  core clock enable; qualifies read_kbd sampling and the gap counter only
//  ps2_valid      in   1  one-clk pulse, ps2_code valid
//  ps2_code       in   8  scancode byte
//  read_kbd       in   1  level, high for the whole CPU read of 177662
//  kbd_available  out  1  FIFO head valid and presentable
//  kbd_data       out  8  head key code (7-bit code in [6:0]; [7]=1 only for F-keys)
//  kbd_ar2        out  1  AR2 (Alt) state captured with the head entry
//  stopkey        out  1  level, F12 held
//  superkey       out  1  level, ScrollLock held
//  keydown        out  1  level, last translated key still held
//  overrun        out  1  sticky: key dropped because FIFO full; cleared on next pop
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty. FSM in IDLE. Modifiers, held code and gap counter cleared.
//  Reset mid-sequence discards any partial prefix or queued keys.
//  Prefix FSM advances on every ps2_valid, independent of ce:
//   IDLE: E0->EXT, F0->BRK, E1->SKIP(cnt=7), other->make(code,ext=0)
//   EXT: F0->EXTBRK, other->make(code,ext=1), then IDLE
//   BRK: ->break(code,ext=0), then IDLE
//   EXTBRK: ->break(code,ext=1), then IDLE
//   SKIP: decrement per byte; IDLE at 0 (Pause sequence swallowed, no key)
//  Modifier keys are never queued:
//   shift = 12|59 held; ctrl = 14|E0 14 held; alt = 11|E0 11 held (alt is the AR2 source)
//   make sets the modifier, break clears it
//  Status keys are never queued: 07(F12) drives stopkey, 7E(ScrollLock) drives superkey;
//  make=1, break=0.
//  Make translation (ext=0 unless noted); an unmapped code is ignored:
//   letters A..Z: unshifted 0x41..0x5A; shift gives 0x61..0x7A; ctrl gives 0x01..0x1A (ctrl wins)
//   digits 0x31..0x39: shift gives code-0x10. '0' 0x30: shift gives 0x30.
//   29 space 0x20 | 5A enter 0x0A | 66 backspace 0x18 | 0D tab 0x09 | 76 esc 0x03
//   E0 6B 0x08 | E0 74 0x19 | E0 75 0x1A | E0 72 0x1B (arrows L,R,U,D)
//   05,06,04,0C,03 (F1..F5) 0x81..0x85
//  On translated make: push {alt,code}; held_code<={ext,code}; keydown<=1.
//  Autorepeat makes push again.
//  On break: if {ext,code}==held_code then keydown<=0. Other breaks leave keydown unchanged.
//  FIFO: entry is 9 bits {ar2,data}. Push when full drops the key and sets overrun.
//   Push and pop in the same clk are both performed; this is legal when full.
//   Head outputs are registered and valid whenever kbd_available=1.
//  Pop: rising edge of read_kbd sampled on ce removes the head and clears overrun.
//   kbd_available then forces 0 until read_kbd is low and GAP_CE ce ticks have elapsed.
//   It reasserts only if the FIFO is non-empty.
//   A read_kbd with FIFO empty has no effect.
//  Latency: ps2_valid of the final byte -> kbd_available=1 on the next clk edge.
//   This holds when the FIFO was empty and no gap is pending.
// TESTING
//  bytes 1C -> kbd_available=1 next clk, kbd_data=0x41, ar2=0, keydown=1;
//   then F0 1C -> keydown=0
//  12,1C,F0 1C,F0 12 -> one entry 0x61. Then 14,23 -> entry 0x04 (ctrl beats shift path)
//  11,16 -> entry 0x31 with kbd_ar2=1. E0 75 -> entry 0x1A, ar2=1.
//   Then F0 11 -> new keys get ar2=0.
//  push 5 keys, no reads, DEPTH=4 -> overrun=1, 4 kept. Each read_kbd pulse (ce) ->
//   available low >=GAP_CE ticks, next entry in order. Overrun cleared at first pop.
//  07 -> stopkey=1; F0 07 -> 0. 7E -> superkey=1. E1 14 77 E1 F0 14 F0 77 -> nothing queued.
//  reset asserted after E0 with 2 keys queued -> all outputs 0.
//   Next 1C decodes as plain 0x41.

Source files
------------

// File: rtl/bk_kbd_if.sv
// Keyboard decoder bus: PS/2 byte stream in, bkcore keyboard register side out.
// The master modport is the environment (PS/2 deserializer plus bkcore),
// the slave modport is the decoder itself.
interface bk_kbd_if;
    logic       ps2_valid;
    logic [7:0] ps2_code;
    logic       read_kbd;
    logic       kbd_available;
    logic [7:0] kbd_data;
    logic       kbd_ar2;
    logic       stopkey;
    logic       superkey;
    logic       keydown;
    logic       overrun;

    modport master (
        output ps2_valid, ps2_code, read_kbd,
        input  kbd_available, kbd_data, kbd_ar2, stopkey, superkey, keydown, overrun
    );

    modport slave (
        input  ps2_valid, ps2_code, read_kbd,
        output kbd_available, kbd_data, kbd_ar2, stopkey, superkey, keydown, overrun
    );
endinterface

// File: rtl/bk_kbd_decoder.sv
// PS/2 set-2 scancode decoder feeding the BK-0010 keyboard register.
// Runs the E0/F0/E1 prefix FSM, tracks shift/ctrl/alt, translates makes into
// BK key codes and queues them with the AR2 (alt) bit in a small FIFO.
// bkcore pops the head on a rising read_kbd (sampled on ce); after a pop
// kbd_available stays low for GAP_CE ce ticks with read_kbd low so that bkcore
// always sees a fresh rising edge for the next key.
module bk_kbd_decoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CE     = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     ce,
    bk_kbd_if.slave  kbd
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = $clog2(GAP_CE + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [GAP_W-1:0] GAP_START = GAP_W'(GAP_CE);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_SKIP   = 3'd4
    } state_t;

    // ---------------------------------------------------------------
    // Key translation helpers
    // ---------------------------------------------------------------

    // {hit, 0..25} for the set-2 letter scancodes A..Z
    function automatic logic [5:0] letter_index(input logic [7:0] code);
        logic [5:0] r;
        case (code)
            8'h1C: r = {1'b1, 5'd0};   // A
            8'h32: r = {1'b1, 5'd1};   // B
            8'h21: r = {1'b1, 5'd2};   // C
            8'h23: r = {1'b1, 5'd3};   // D
            8'h24: r = {1'b1, 5'd4};   // E
            8'h2B: r = {1'b1, 5'd5};   // F
            8'h34: r = {1'b1, 5'd6};   // G
            8'h33: r = {1'b1, 5'd7};   // H
            8'h43: r = {1'b1, 5'd8};   // I
            8'h3B: r = {1'b1, 5'd9};   // J
            8'h42: r = {1'b1, 5'd10};  // K
            8'h4B: r = {1'b1, 5'd11};  // L
            8'h3A: r = {1'b1, 5'd12};  // M
            8'h31: r = {1'b1, 5'd13};  // N
            8'h44: r = {1'b1, 5'd14};  // O
            8'h4D: r = {1'b1, 5'd15};  // P
            8'h15: r = {1'b1, 5'd16};  // Q
            8'h2D: r = {1'b1, 5'd17};  // R
            8'h1B: r = {1'b1, 5'd18};  // S
            8'h2C: r = {1'b1, 5'd19};  // T
            8'h3C: r = {1'b1, 5'd20};  // U
            8'h2A: r = {1'b1, 5'd21};  // V
            8'h1D: r = {1'b1, 5'd22};  // W
            8'h22: r = {1'b1, 5'd23};  // X
            8'h35: r = {1'b1, 5'd24};  // Y
            8'h1A: r = {1'b1, 5'd25};  // Z
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // {hit, 0..9} for the top-row digit scancodes
    function automatic logic [4:0] digit_value(input logic [7:0] code);
        logic [4:0] r;
        case (code)
            8'h45: r = {1'b1, 4'd0};
            8'h16: r = {1'b1, 4'd1};
            8'h1E: r = {1'b1, 4'd2};
            8'h26: r = {1'b1, 4'd3};
            8'h25: r = {1'b1, 4'd4};
            8'h2E: r = {1'b1, 4'd5};
            8'h36: r = {1'b1, 4'd6};
            8'h3D: r = {1'b1, 4'd7};
            8'h3E: r = {1'b1, 4'd8};
            8'h46: r = {1'b1, 4'd9};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    // {hit, BK code} for a make; ctrl outranks shift on letters
    function automatic logic [8:0] translate_key(input logic [7:0] code, input logic ext,
                                                 input logic shift, input logic ctrl);
        logic [5:0] letter;
        logic [4:0] digit;
        logic [8:0] r;
        letter = letter_index(code);
        digit  = digit_value(code);
        r      = 9'h000;
        if (ext) begin
            case (code)
                8'h6B:   r = {1'b1, 8'h08};  // left
                8'h74:   r = {1'b1, 8'h19};  // right
                8'h75:   r = {1'b1, 8'h1A};  // up
                8'h72:   r = {1'b1, 8'h1B};  // down
                default: r = 9'h000;
            endcase
        end else if (letter[5]) begin
            if (ctrl) begin
                r = {1'b1, 3'b000, letter[4:0] + 5'd1};
            end else if (shift) begin
                r = {1'b1, 8'h61 + {3'b000, letter[4:0]}};
            end else begin
                r = {1'b1, 8'h41 + {3'b000, letter[4:0]}};
            end
        end else if (digit[4]) begin
            // shifted 1..9 drop to 0x21..0x29, '0' stays 0x30 either way
            if (shift && (digit[3:0] != 4'd0)) begin
                r = {1'b1, 4'h2, digit[3:0]};
            end else begin
                r = {1'b1, 4'h3, digit[3:0]};
            end
        end else begin
            case (code)
                8'h29:   r = {1'b1, 8'h20};  // space
                8'h5A:   r = {1'b1, 8'h0A};  // enter
                8'h66:   r = {1'b1, 8'h18};  // backspace
                8'h0D:   r = {1'b1, 8'h09};  // tab
                8'h76:   r = {1'b1, 8'h03};  // esc
                8'h05:   r = {1'b1, 8'h81};  // F1
                8'h06:   r = {1'b1, 8'h82};  // F2
                8'h04:   r = {1'b1, 8'h83};  // F3
                8'h0C:   r = {1'b1, 8'h84};  // F4
                8'h03:   r = {1'b1, 8'h85};  // F5
                default: r = 9'h000;
            endcase
        end
        return r;
    endfunction

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    state_t           state_r;
    logic [2:0]       skip_r;
    logic             shift_r, ctrl_r, alt_r;
    logic             stop_r, super_r, keydown_r;
    logic [8:0]       held_code_r;
    logic [8:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [GAP_W-1:0] gap_r;
    logic             read_prev_r;
    logic             avail_r, overrun_r;
    logic [8:0]       head_r;

    // Decoder combinational signals
    state_t           state_next_s;
    logic [2:0]       skip_next_s;
    logic             make_s, break_s, key_ext_s;
    logic [7:0]       key_code_s;
    logic             is_shift_s, is_ctrl_s, is_alt_s, is_stop_s, is_super_s;
    logic [8:0]       trans_s;
    logic             push_req_s;
    logic [8:0]       push_entry_s;

    // FIFO combinational signals
    logic             pop_s, full_s, push_s, drop_s;
    logic [CNT_W-1:0] count_after_pop_s, count_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [8:0]       head_next_s;
    logic [GAP_W-1:0] gap_next_s;
    logic             avail_next_s;

    // Prefix FSM next state and make/break event generation for the current byte
    always_comb begin
        make_s       = 1'b0;
        break_s      = 1'b0;
        key_ext_s    = 1'b0;
        key_code_s   = kbd.ps2_code;
        state_next_s = state_r;
        skip_next_s  = skip_r;
        if (kbd.ps2_valid) begin
            case (state_r)
                ST_IDLE: begin
                    if (kbd.ps2_code == 8'hE0) begin
                        state_next_s = ST_EXT;
                    end else if (kbd.ps2_code == 8'hF0) begin
                        state_next_s = ST_BRK;
                    end else if (kbd.ps2_code == 8'hE1) begin
                        state_next_s = ST_SKIP;
                        skip_next_s  = 3'd7;
                    end else begin
                        make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (kbd.ps2_code == 8'hF0) begin
                        state_next_s = ST_EXTBRK;
                    end else begin
                        make_s       = 1'b1;
                        key_ext_s    = 1'b1;
                        state_next_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    break_s      = 1'b1;
                    state_next_s = ST_IDLE;
                end
                ST_EXTBRK: begin
                    break_s      = 1'b1;
                    key_ext_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end
                ST_SKIP: begin
                    // the remaining Pause bytes are swallowed without producing a key
                    if (skip_r <= 3'd1) begin
                        skip_next_s  = 3'd0;
                        state_next_s = ST_IDLE;
                    end else begin
                        skip_next_s  = skip_r - 3'd1;
                        state_next_s = ST_SKIP;
                    end
                end
                default: begin
                    skip_next_s  = 3'd0;
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    assign is_shift_s   = !key_ext_s && ((key_code_s == 8'h12) || (key_code_s == 8'h59));
    assign is_ctrl_s    = (key_code_s == 8'h14);
    assign is_alt_s     = (key_code_s == 8'h11);
    assign is_stop_s    = !key_ext_s && (key_code_s == 8'h07);
    assign is_super_s   = !key_ext_s && (key_code_s == 8'h7E);
    assign trans_s      = translate_key(key_code_s, key_ext_s, shift_r, ctrl_r);
    assign push_req_s   = make_s && trans_s[8] && !is_shift_s && !is_ctrl_s && !is_alt_s
                          && !is_stop_s && !is_super_s;
    assign push_entry_s = {alt_r, trans_s[7:0]};

    // Prefix FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            skip_r  <= 3'd0;
        end else begin
            state_r <= state_next_s;
            skip_r  <= skip_next_s;
        end
    end

    // Modifier, status-key and held-key tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_r     <= 1'b0;
            ctrl_r      <= 1'b0;
            alt_r       <= 1'b0;
            stop_r      <= 1'b0;
            super_r     <= 1'b0;
            keydown_r   <= 1'b0;
            held_code_r <= 9'h000;
        end else begin
            if ((make_s || break_s) && is_shift_s) shift_r <= make_s;
            if ((make_s || break_s) && is_ctrl_s)  ctrl_r  <= make_s;
            if ((make_s || break_s) && is_alt_s)   alt_r   <= make_s;
            if ((make_s || break_s) && is_stop_s)  stop_r  <= make_s;
            if ((make_s || break_s) && is_super_s) super_r <= make_s;
            if (push_req_s) begin
                held_code_r <= {key_ext_s, key_code_s};
                keydown_r   <= 1'b1;
            end else if (break_s && ({key_ext_s, key_code_s} == held_code_r)) begin
                keydown_r   <= 1'b0;
            end
        end
    end

    // Pop detection and FIFO bookkeeping; a pop frees a slot for a push in the same clk
    assign pop_s             = ce && kbd.read_kbd && !read_prev_r && (count_r != {CNT_W{1'b0}});
    assign full_s            = (count_r == FULL_CNT);
    assign push_s            = push_req_s && (!full_s || pop_s);
    assign drop_s            = push_req_s && full_s && !pop_s;
    assign count_after_pop_s = pop_s ? (count_r - CNT_W'(1)) : count_r;
    assign count_next_s      = push_s ? (count_after_pop_s + CNT_W'(1)) : count_after_pop_s;
    assign rd_ptr_next_s     = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    // when the queue drains to nothing, the incoming key becomes the head directly
    assign head_next_s       = (count_after_pop_s == {CNT_W{1'b0}}) ? push_entry_s
                                                                     : mem_r[rd_ptr_next_s];

    // Gap counter: restarts on a pop, counts down on ce ticks only while read_kbd is low
    always_comb begin
        gap_next_s = gap_r;
        if (pop_s) begin
            gap_next_s = GAP_START;
        end else if (ce && !kbd.read_kbd && (gap_r != {GAP_W{1'b0}})) begin
            gap_next_s = gap_r - GAP_W'(1);
        end else begin
            gap_next_s = gap_r;
        end
    end

    assign avail_next_s = (count_next_s != {CNT_W{1'b0}}) && (gap_next_s == {GAP_W{1'b0}});

    // FIFO storage and pointers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 9'h000;
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_entry_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Read strobe history, gap counter and registered head/status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_prev_r <= 1'b0;
            gap_r       <= {GAP_W{1'b0}};
            avail_r     <= 1'b0;
            head_r      <= 9'h000;
            overrun_r   <= 1'b0;
        end else begin
            if (ce) read_prev_r <= kbd.read_kbd;
            gap_r   <= gap_next_s;
            avail_r <= avail_next_s;
            head_r  <= head_next_s;
            if (pop_s) begin
                overrun_r <= 1'b0;
            end else if (drop_s) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign kbd.kbd_available = avail_r;
    assign kbd.kbd_data      = head_r[7:0];
    assign kbd.kbd_ar2       = head_r[8];
    assign kbd.stopkey       = stop_r;
    assign kbd.superkey      = super_r;
    assign kbd.keydown       = keydown_r;
    assign kbd.overrun       = overrun_r;

endmodule

// File: tb/tb_bk_kbd_decoder.sv
// Directed bench for bk_kbd_decoder: prefix FSM, modifiers, translation,
// status keys, FIFO overflow/gap behaviour and reset mid-sequence.
module tb_bk_kbd_decoder;
    localparam int GAP_CE = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic ce    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bk_kbd_if kbd ();

    bk_kbd_decoder #(.FIFO_DEPTH(4), .GAP_CE(GAP_CE)) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .kbd   (kbd)
    );

    always #5 clk = ~clk;
    // ce high on every other clock
    always @(negedge clk) ce = ~ce;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        kbd.ps2_valid = 1'b1;
        kbd.ps2_code  = b;
        @(negedge clk);
        kbd.ps2_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [7:0] exp_data, input logic exp_ar2, input string name);
        int n = 0;
        while (!kbd.kbd_available && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (kbd.kbd_available !== 1'b1) begin
            errors++;
            $display("FAIL %s avail: kbd_available=%b required 1", name, kbd.kbd_available);
        end
        checks++;
        if (kbd.kbd_data !== exp_data) begin
            errors++;
            $display("FAIL %s data: kbd_data=%h required %h", name, kbd.kbd_data, exp_data);
        end
        checks++;
        if (kbd.kbd_ar2 !== exp_ar2) begin
            errors++;
            $display("FAIL %s ar2: kbd_ar2=%b required %b", name, kbd.kbd_ar2, exp_ar2);
        end
        kbd.read_kbd = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (kbd.kbd_available !== 1'b0) begin
            errors++;
            $display("FAIL %s popped: kbd_available=%b required 0", name, kbd.kbd_available);
        end
        kbd.read_kbd = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_bit(input logic actual, input logic expected, input string name);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, actual, expected);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_bit(kbd.kbd_available, 1'b0, {name, " kbd_available"});
        check_bit(kbd.kbd_ar2,       1'b0, {name, " kbd_ar2"});
        check_bit(kbd.stopkey,       1'b0, {name, " stopkey"});
        check_bit(kbd.superkey,      1'b0, {name, " superkey"});
        check_bit(kbd.keydown,       1'b0, {name, " keydown"});
        check_bit(kbd.overrun,       1'b0, {name, " overrun"});
        checks++;
        if (kbd.kbd_data !== 8'h00) begin
            errors++;
            $display("FAIL %s kbd_data: got %h required 00", name, kbd.kbd_data);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        send_byte(8'h1C);
        check_bit(kbd.kbd_available, 1'b1, "basic latency avail");
        checks++;
        if (kbd.kbd_data !== 8'h41) begin
            errors++;
            $display("FAIL basic data: got %h required 41", kbd.kbd_data);
        end
        check_bit(kbd.kbd_ar2, 1'b0, "basic ar2");
        check_bit(kbd.keydown, 1'b1, "basic keydown make");
        send_byte(8'hF0);
        send_byte(8'h1C);
        check_bit(kbd.keydown, 1'b0, "basic keydown break");
        pop_expect(8'h41, 1'b0, "basic pop");
    endtask

    task automatic test_modifiers();
        send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h12);
        pop_expect(8'h61, 1'b0, "shift a");
        check_bit(kbd.kbd_available, 1'b0, "shift single entry");
        send_byte(8'h14); send_byte(8'h23);
        pop_expect(8'h04, 1'b0, "ctrl d");
        send_byte(8'hF0); send_byte(8'h23); send_byte(8'hF0); send_byte(8'h14);
        send_byte(8'h11); send_byte(8'h16);
        pop_expect(8'h31, 1'b1, "alt 1");
        send_byte(8'hE0); send_byte(8'h75);
        pop_expect(8'h1A, 1'b1, "alt up");
        send_byte(8'hF0); send_byte(8'h11);
        send_byte(8'h1C);
        pop_expect(8'h41, 1'b0, "alt released");
        send_byte(8'hF0); send_byte(8'h1C);
    endtask

    task automatic test_translate();
        // {ext, shift, scancode, expected}
        logic [17:0] tbl [9] = '{
            {1'b0, 1'b1, 8'h16, 8'h21}, {1'b0, 1'b1, 8'h45, 8'h30},
            {1'b0, 1'b0, 8'h45, 8'h30}, {1'b0, 1'b0, 8'h5A, 8'h0A},
            {1'b0, 1'b0, 8'h05, 8'h81}, {1'b0, 1'b0, 8'h03, 8'h85},
            {1'b1, 1'b0, 8'h6B, 8'h08}, {1'b1, 1'b0, 8'h72, 8'h1B},
            {1'b0, 1'b0, 8'h29, 8'h20}
        };
        for (int i = 0; i < 9; i++) begin
            if (tbl[i][16]) send_byte(8'h12);
            if (tbl[i][17]) send_byte(8'hE0);
            send_byte(tbl[i][15:8]);
            pop_expect(tbl[i][7:0], 1'b0, $sformatf("translate %0d", i));
            if (tbl[i][17]) send_byte(8'hE0);
            send_byte(8'hF0);
            send_byte(tbl[i][15:8]);
            if (tbl[i][16]) begin
                send_byte(8'hF0);
                send_byte(8'h12);
            end
        end
        send_byte(8'h0E);
        repeat (3) @(negedge clk);
        check_bit(kbd.kbd_available, 1'b0, "unmapped ignored");
        send_byte(8'hF0); send_byte(8'h0E);
    endtask

    task automatic test_status();
        send_byte(8'h07);
        check_bit(kbd.stopkey, 1'b1, "stopkey make");
        check_bit(kbd.kbd_available, 1'b0, "stopkey not queued");
        send_byte(8'hF0); send_byte(8'h07);
        check_bit(kbd.stopkey, 1'b0, "stopkey break");
        send_byte(8'h7E);
        check_bit(kbd.superkey, 1'b1, "superkey make");
        send_byte(8'hF0); send_byte(8'h7E);
        check_bit(kbd.superkey, 1'b0, "superkey break");
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        repeat (3) @(negedge clk);
        check_bit(kbd.kbd_available, 1'b0, "pause swallowed");
        send_byte(8'h1C);
        pop_expect(8'h41, 1'b0, "after pause");
        send_byte(8'hF0); send_byte(8'h1C);
    endtask

    task automatic test_overflow();
        int ticks = 0;
        int n = 0;
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
        send_byte(8'h24);
        check_bit(kbd.overrun, 1'b1, "overrun set");
        check_bit(kbd.kbd_available, 1'b1, "overrun avail");
        checks++;
        if (kbd.kbd_data !== 8'h41) begin
            errors++;
            $display("FAIL overflow head: got %h required 41", kbd.kbd_data);
        end
        kbd.read_kbd = 1'b1;
        repeat (4) @(negedge clk);
        check_bit(kbd.kbd_available, 1'b0, "overflow first pop");
        check_bit(kbd.overrun, 1'b0, "overrun cleared");
        kbd.read_kbd = 1'b0;
        while (n < 30) begin
            @(posedge clk);
            if (ce) ticks++;
            #1;
            n++;
            if (kbd.kbd_available) break;
        end
        check_bit(kbd.kbd_available, 1'b1, "gap reassert");
        checks++;
        if (ticks < GAP_CE) begin
            errors++;
            $display("FAIL gap length: got %0d ce ticks required >= %0d", ticks, GAP_CE);
        end
        pop_expect(8'h42, 1'b0, "overflow B");
        pop_expect(8'h43, 1'b0, "overflow C");
        pop_expect(8'h44, 1'b0, "overflow D");
        repeat (4) @(negedge clk);
        check_bit(kbd.kbd_available, 1'b0, "overflow drained");
        send_byte(8'hF0); send_byte(8'h24);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h21); send_byte(8'h23);
        check_bit(kbd.overrun, 1'b0, "full no overrun");
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!ce && n < 10);
        kbd.read_kbd  = 1'b1;
        kbd.ps2_valid = 1'b1;
        kbd.ps2_code  = 8'h24;
        @(negedge clk);
        kbd.ps2_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_bit(kbd.overrun, 1'b0, "push+pop when full");
        kbd.read_kbd = 1'b0;
        pop_expect(8'h42, 1'b0, "b2b B");
        pop_expect(8'h43, 1'b0, "b2b C");
        pop_expect(8'h44, 1'b0, "b2b D");
        pop_expect(8'h45, 1'b0, "b2b E");
        send_byte(8'hF0); send_byte(8'h24);
    endtask

    task automatic test_reset_mid();
        send_byte(8'h1C); send_byte(8'h32); send_byte(8'h07); send_byte(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset mid");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        send_byte(8'h1C);
        pop_expect(8'h41, 1'b0, "after reset");
    endtask

    initial begin
        kbd.ps2_valid = 1'b0;
        kbd.ps2_code  = 8'h00;
        kbd.read_kbd  = 1'b0;
        test_reset();
        test_basic();
        test_modifiers();
        test_translate();
        test_status();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
